// File: rtl/board_io_pkg.sv
// Shared constants for the board-I/O front end: clock rate, default channel counts
// and the debounce / blink timing derived from them.
package board_io_pkg;

    localparam int CLK_HZ                  = 100_000_000;
    localparam int CYCLES_PER_MS           = CLK_HZ / 1000;
    localparam int DEFAULT_DEBOUNCE_MS     = 10;
    localparam int DEFAULT_BLINK_HZ        = 2;
    localparam int DEFAULT_NUM_SW          = 16;
    localparam int DEFAULT_NUM_LED         = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_MS * CYCLES_PER_MS;
    localparam int DEFAULT_BLINK_DIV       = CLK_HZ / (2 * DEFAULT_BLINK_HZ);

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: multi-flop synchroniser, stability counter, debounced level
// and registered one-cycle rise/fall pulses.
module sw_debounce_chan
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock100,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall,
    output logic rise_next,
    output logic fall_next
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronised level disagrees with the clean level,
    // so it can never pass CNT_LAST and never wraps.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sw_raw};
        cnt_d   = '0;
        clean_d = clean_q;
        if (s != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_next = clean_d & ~clean_q;
        fall_next = ~clean_d & clean_q;
    end

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_next;
            fall_q  <= fall_next;
        end
    end

    assign sw_clean = clean_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;

endmodule

// File: rtl/board_io_conditioner.sv
// Board-I/O front end: debounced switches with edge events and sticky change flags,
// plus registered LEDs with a per-bit blink mask driven by a free-running timer.
module board_io_conditioner
    import board_io_pkg::*;
#(
    parameter int NUM_SW          = DEFAULT_NUM_SW,
    parameter int NUM_LED         = DEFAULT_NUM_LED,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_DIV       = DEFAULT_BLINK_DIV
) (
    input  logic               clock100,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_SW-1:0]  sw_clean,
    output logic [NUM_SW-1:0]  sw_rise,
    output logic [NUM_SW-1:0]  sw_fall,
    output logic [NUM_SW-1:0]  sw_changed,
    input  logic [NUM_SW-1:0]  chg_clear,
    input  logic [NUM_LED-1:0] led_wdata,
    input  logic               led_we,
    input  logic               led_mode_we,
    output logic [NUM_LED-1:0] led_out
);

    localparam int            BW        = cnt_width(BLINK_DIV);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

    logic [NUM_SW-1:0]  rise_next, fall_next;
    logic [NUM_SW-1:0]  changed_q, changed_d;
    logic [NUM_LED-1:0] led_reg_q, led_reg_d;
    logic [NUM_LED-1:0] blink_mask_q, blink_mask_d;
    logic [NUM_LED-1:0] led_out_q, led_out_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic               bcnt_wrap;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
        sw_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock100  (clock100),
            .reset     (reset),
            .sw_raw    (sw_raw[i]),
            .sw_clean  (sw_clean[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .rise_next (rise_next[i]),
            .fall_next (fall_next[i])
        );
    end

    // Sticky flags use the next-cycle events so a set lands together with the pulse and beats a clear.
    always_comb begin
        changed_d    = (changed_q & ~chg_clear) | rise_next | fall_next;
        led_reg_d    = led_we ? led_wdata : led_reg_q;
        blink_mask_d = led_mode_we ? led_wdata : blink_mask_q;
        bcnt_wrap    = (bcnt_q == BCNT_LAST);
        bcnt_d       = bcnt_wrap ? '0 : bcnt_q + 1'b1;
        phase_d      = phase_q ^ bcnt_wrap;
        led_out_d    = led_reg_q & ~(blink_mask_q & {NUM_LED{~phase_q}});
    end

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            changed_q    <= '0;
            led_reg_q    <= '0;
            blink_mask_q <= '0;
            led_out_q    <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b0;
        end else begin
            changed_q    <= changed_d;
            led_reg_q    <= led_reg_d;
            blink_mask_q <= blink_mask_d;
            led_out_q    <= led_out_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
        end
    end

    assign sw_changed = changed_q;
    assign led_out    = led_out_q;

endmodule
